seg7_reader: RTL and testbench

SEG7_READER -- requirements
Module: seg7_reader

---
 rtl/seg7_reader.sv | 101 ++++++++++
 tb/tb_seg7_reader.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seg7_reader.sv
// seg7_reader: debounces a multiplexed active-low 7-segment scan into decoded 4-digit frames
module seg7_reader #(
  parameter int STABLE_CNT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  seg,
  input  logic [3:0]  dig_en,
  input  logic        frame_ready,
  output logic [15:0] value,
  output logic [3:0]  dp,
  output logic [3:0]  err,
  output logic        frame_valid,
  output logic        overrun
);
  localparam logic [3:0] ST = 4'(STABLE_CNT);
  typedef enum logic {EMPTY, PENDING} state_t;
  state_t state;
  logic [7:0] s_seg, p_seg;
  logic [3:0] s_en, p_en, cnt, cnt_nxt, mask, sh_dp, sh_err, code;
  logic [15:0] sh_val;
  logic [1:0] idx;
  logic onehot, cap, complete, valid;
  always_comb begin
    valid = 1'b1;
    code = 4'h0;
    case (s_seg[6:0])
      7'b1000000: code = 4'h0;
      7'b1111001: code = 4'h1;
      7'b0100100: code = 4'h2;
      7'b0110000: code = 4'h3;
      7'b0011001: code = 4'h4;
      7'b0010010: code = 4'h5;
      7'b0000010: code = 4'h6;
      7'b1111000: code = 4'h7;
      7'b0000000: code = 4'h8;
      7'b0010000: code = 4'h9;
      7'b0111110: code = 4'hF;
      7'b1111111: code = 4'hE;
      default:    valid = 1'b0;
    endcase
  end
  assign onehot = (s_en != 4'h0) && ((s_en & (s_en - 4'd1)) == 4'h0);
  assign cnt_nxt = !onehot ? 4'd0 :
                   ({s_seg, s_en} != {p_seg, p_en}) ? 4'd1 :
                   (cnt == ST) ? cnt : cnt + 4'd1;
  // capture only on the edge the counter first arrives at the threshold
  assign cap = onehot && cnt_nxt == ST && cnt != ST;
  assign idx = s_en[1] ? 2'd1 : s_en[2] ? 2'd2 : s_en[3] ? 2'd3 : 2'd0;
  assign complete = &mask;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s_seg <= 8'h0;
      s_en <= 4'h0;
      p_seg <= 8'h0;
      p_en <= 4'h0;
      cnt <= 4'd0;
      mask <= 4'h0;
      sh_val <= 16'h0;
      sh_dp <= 4'h0;
      sh_err <= 4'h0;
    end else begin
      s_seg <= seg;
      s_en <= dig_en;
      p_seg <= s_seg;
      p_en <= s_en;
      cnt <= cnt_nxt;
      mask <= (complete ? 4'h0 : mask) | (cap ? s_en : 4'h0);
      if (cap) begin
        sh_dp[idx] <= ~s_seg[7];
        sh_err[idx] <= ~valid;
        if (valid) sh_val[{idx, 2'b00} +: 4] <= code;
      end
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= EMPTY;
      value <= 16'h0;
      dp <= 4'h0;
      err <= 4'h0;
      frame_valid <= 1'b0;
      overrun <= 1'b0;
    end else if (state == EMPTY) begin
      if (complete) begin
        value <= sh_val;
        dp <= sh_dp;
        err <= sh_err;
        frame_valid <= 1'b1;
        state <= PENDING;
      end
    end else if (frame_valid && frame_ready && complete) begin
      value <= sh_val;
      dp <= sh_dp;
      err <= sh_err;
    end else if (frame_valid && frame_ready) begin
      frame_valid <= 1'b0;
      state <= EMPTY;
    end else if (complete) begin
      overrun <= 1'b1;
    end
endmodule

// File: tb/tb_seg7_reader.sv
// tb_seg7_reader: directed and random scan stimulus checked every cycle against a behavioural model
module tb_seg7_reader;
  localparam int S = 4;
  logic clk = 1'b0, reset = 1'b1, frame_ready = 1'b1;
  logic [7:0] seg = 8'hFF;
  logic [3:0] dig_en = 4'h0;
  logic [15:0] value;
  logic [3:0] dp, err;
  logic frame_valid, overrun;
  int checks = 0, fails = 0, fvc = 0;
  seg7_reader #(.STABLE_CNT(S)) dut (
    .clk(clk), .reset(reset), .seg(seg), .dig_en(dig_en), .frame_ready(frame_ready),
    .value(value), .dp(dp), .err(err), .frame_valid(frame_valid), .overrun(overrun)
  );
  always #5 clk = ~clk;
  // pattern for each code; 8'h80 never matches a 7-bit pattern, so codes A..D are unused
  logic [7:0] tab [16] = '{8'h40, 8'h79, 8'h24, 8'h30, 8'h19, 8'h12, 8'h02, 8'h78,
                           8'h00, 8'h10, 8'h80, 8'h80, 8'h80, 8'h80, 8'h7F, 8'h3E};
  logic [15:0] m_val;
  logic [3:0] m_dp, m_err, sh_dp, sh_err, got;
  logic [3:0] sh_nib [4];
  logic m_fv, m_ov, full;
  logic [11:0] smp, prv;
  int run;
  task automatic model_reset();
    m_val = 16'h0; m_dp = 4'h0; m_err = 4'h0; m_fv = 1'b0; m_ov = 1'b0;
    sh_dp = 4'h0; sh_err = 4'h0; got = 4'h0; full = 1'b0;
    for (int k = 0; k < 4; k++) sh_nib[k] = 4'h0;
    smp = 12'h0; prv = 12'h0; run = 0;
  endtask
  task automatic model_step();
    int nr, i;
    bit cap, ok;
    logic [3:0] c;
    logic [11:0] s;
    s = smp;
    nr = ($countones(s[3:0]) != 1) ? 0 : (s != prv) ? 1 : (run < S ? run + 1 : S);
    cap = (nr == S) && (run != S);
    if (full && (!m_fv || frame_ready)) begin
      m_val = {sh_nib[3], sh_nib[2], sh_nib[1], sh_nib[0]};
      m_dp = sh_dp; m_err = sh_err; m_fv = 1'b1;
    end else if (full) m_ov = 1'b1;
    else if (m_fv && frame_ready) m_fv = 1'b0;
    if (full) got = 4'h0;
    if (cap) begin
      i = 0; ok = 1'b0; c = 4'h0;
      for (int k = 0; k < 4; k++) if (s[k]) i = k;
      for (int k = 0; k < 16; k++) if (tab[k] == {1'b0, s[10:4]}) begin ok = 1'b1; c = 4'(k); end
      if (ok) sh_nib[i] = c;
      sh_err[i] = !ok;
      sh_dp[i] = !s[11];
      got[i] = 1'b1;
    end
    full = (got == 4'hF);
    prv = s; smp = {seg, dig_en}; run = nr;
  endtask
  task automatic chk(string n, logic [15:0] a, logic [15:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic cmp_all();
    chk("value", value, m_val);
    chk("dp", {12'h0, dp}, {12'h0, m_dp});
    chk("err", {12'h0, err}, {12'h0, m_err});
    chk("frame_valid", {15'h0, frame_valid}, {15'h0, m_fv});
    chk("overrun", {15'h0, overrun}, {15'h0, m_ov});
  endtask
  task automatic tick();
    @(posedge clk);
    if (!reset) model_step();
    @(negedge clk);
    cmp_all();
    if (frame_valid) fvc++;
  endtask
  task automatic show(int i, logic [7:0] p, int n);
    dig_en = 4'(1 << i); seg = p;
    repeat (n) tick();
  endtask
  task automatic idle(int n);
    dig_en = 4'h0; seg = 8'hFF;
    repeat (n) tick();
  endtask
  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cmp_all();
    fvc = 0;
  endtask
  task automatic lit(string n, logic [15:0] a, logic [15:0] m, logic [15:0] e);
    chk(n, a, e);
    chk({n, "_model"}, m, e);
  endtask
  task automatic scan(logic [7:0] p0, logic [7:0] p1, logic [7:0] p2, logic [7:0] p3);
    show(0, p0, 4); show(1, p1, 4); show(2, p2, 4); show(3, p3, 4);
  endtask
  initial begin
    model_reset();
    @(negedge clk);
    do_reset();
    lit("reset_value", value, m_val, 16'h0);
    lit("reset_flags", {dp, err, 3'b0, frame_valid, 3'b0, overrun}, {m_dp, m_err, 3'b0, m_fv, 3'b0, m_ov}, 16'h0);
    idle(3);
    fvc = 0;
    scan(8'hC0, 8'hF9, 8'hA4, 8'hB0); idle(4);
    lit("basic_value", value, m_val, 16'h3210);
    lit("basic_dp_err", {8'h0, dp, err}, {8'h0, m_dp, m_err}, 16'h0);
    chk("basic_pulses", 16'(fvc), 16'd1);
    do_reset();
    show(0, 8'hC0, 4); show(1, 8'hF9, 4); show(2, 8'hA4, 3); show(3, 8'hB0, 4); idle(3);
    chk("short_no_frame", 16'(fvc), 16'd0);
    scan(8'hC0, 8'hF9, 8'hA4, 8'hB0); idle(4);
    chk("short_second_pass", 16'(fvc), 16'd1);
    lit("short_value", value, m_val, 16'h3210);
    do_reset();
    scan(8'hC0, 8'h7F, 8'hA4, 8'hBE); idle(4);
    lit("blank_dash_value", value, m_val, 16'hF2E0);
    lit("blank_dash_dp", {12'h0, dp}, {12'h0, m_dp}, 16'h0002);
    do_reset();
    scan(8'h55, 8'hF9, 8'hA4, 8'hB0); idle(4);
    lit("invalid_err", {12'h0, err}, {12'h0, m_err}, 16'h0001);
    lit("invalid_value", value, m_val, 16'h3210);
    do_reset();
    frame_ready = 1'b0;
    scan(8'hC0, 8'hF9, 8'hA4, 8'hB0);
    scan(8'h90, 8'h80, 8'hF8, 8'h82); idle(3);
    lit("overrun_flag", {15'h0, overrun}, {15'h0, m_ov}, 16'h1);
    lit("overrun_held", value, m_val, 16'h3210);
    lit("overrun_valid", {15'h0, frame_valid}, {15'h0, m_fv}, 16'h1);
    frame_ready = 1'b1;
    tick();
    lit("overrun_drop", {15'h0, frame_valid}, {15'h0, m_fv}, 16'h0);
    do_reset();
    show(0, 8'hC0, 4); show(1, 8'hF9, 4); show(3, 8'hB0, 4);
    dig_en = 4'b0110; seg = 8'hA4;
    repeat (10) tick();
    idle(4);
    chk("multi_hot_no_frame", 16'(fvc), 16'd0);
    do_reset();
    scan(8'hC0, 8'hF9, 8'hA4, 8'hB0); idle(4);
    show(0, 8'h90, 4); show(1, 8'h80, 4); show(2, 8'hF8, 4);
    do_reset();
    lit("midreset_value", value, m_val, 16'h0);
    lit("midreset_flags", {dp, err, 3'b0, frame_valid, 3'b0, overrun}, {m_dp, m_err, 3'b0, m_fv, 3'b0, m_ov}, 16'h0);
    show(3, 8'h82, 4); idle(4);
    chk("midreset_no_frame", 16'(fvc), 16'd0);
    do_reset();
    for (int n = 0; n < 400; n++) begin
      int r, k;
      r = $urandom_range(0, 9);
      k = $urandom_range(0, 11);
      k = (k > 9) ? k + 4 : k;
      dig_en = (r == 0) ? 4'($urandom_range(0, 15)) : 4'(1 << $urandom_range(0, 3));
      seg = ($urandom_range(0, 9) < 7) ? {1'($urandom_range(0, 1)), tab[k][6:0]} : 8'($urandom);
      frame_ready = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(1, 6)) tick();
      if ($urandom_range(0, 149) == 0) begin
        @(negedge clk);
        do_reset();
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
